// File: rtl/scrambler_arb.sv
// scrambler_arb: frame-granular round-robin arbiter feeding a scrambler.
// Two AXI-Stream requesters are arbitrated a whole frame at a time; the
// winning beats are registered onto m_axis with a one-cycle latency and a
// per-frame scrambler seed is strobed at the start of every grant.
// Optional feature macro: SCRAMBLER_ARB_SEED_ROTATE_EN
//   defined   -> seed register starts at SEED_INIT and advances 1..127 per frame
//   undefined -> seed_tdata is the constant SEED_INIT (no seed register)
module scrambler_arb #(
  parameter int         WIDTH     = 32,
  parameter logic [6:0] SEED_INIT = 7'h7F
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [WIDTH-1:0] s0_axis_tdata,
  input  logic [3:0]       s0_axis_tuser,
  input  logic             s0_axis_tvalid,
  input  logic             s0_axis_tlast,
  output logic             s0_axis_tready,
  input  logic [WIDTH-1:0] s1_axis_tdata,
  input  logic [3:0]       s1_axis_tuser,
  input  logic             s1_axis_tvalid,
  input  logic             s1_axis_tlast,
  output logic             s1_axis_tready,
  output logic [WIDTH-1:0] m_axis_tdata,
  output logic [3:0]       m_axis_tuser,
  output logic             m_axis_tvalid,
  output logic             m_axis_tlast,
  output logic             m_axis_tid,
  input  logic             m_axis_tready,
  output logic [6:0]       seed_tdata,
  output logic             seed_tvalid,
  output logic [15:0]      frame_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic   last_served;   // requester that completed the most recent frame

  // The output register can take a new beat when empty or draining this cycle.
  logic out_free;
  logic acc0;
  logic acc1;
  logic beat_acc;
  logic frame_done;

  assign out_free       = !m_axis_tvalid || m_axis_tready;
  assign s0_axis_tready = (state == GRANT0) && out_free;
  assign s1_axis_tready = (state == GRANT1) && out_free;
  assign acc0           = s0_axis_tvalid && s0_axis_tready;
  assign acc1           = s1_axis_tvalid && s1_axis_tready;
  assign beat_acc       = acc0 || acc1;
  assign frame_done     = (acc0 && s0_axis_tlast) || (acc1 && s1_axis_tlast);

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: round-robin pick in IDLE, hold the grant until tlast.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (s0_axis_tvalid && s1_axis_tvalid) begin
          state_next = last_served ? GRANT0 : GRANT1;
        end else if (s0_axis_tvalid) begin
          state_next = GRANT0;
        end else if (s1_axis_tvalid) begin
          state_next = GRANT1;
        end else begin
          state_next = IDLE;
        end
      end
      GRANT0: begin
        if (frame_done) begin
          state_next = IDLE;
        end else begin
          state_next = GRANT0;
        end
      end
      GRANT1: begin
        if (frame_done) begin
          state_next = IDLE;
        end else begin
          state_next = GRANT1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output beat register: load on accept, clear valid on a bare handshake, else hold.
  always_ff @(posedge aclk) begin
    if (areset) begin
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 4'd0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= 1'b0;
    end else if (beat_acc) begin
      m_axis_tdata  <= acc1 ? s1_axis_tdata : s0_axis_tdata;
      m_axis_tuser  <= acc1 ? s1_axis_tuser : s0_axis_tuser;
      m_axis_tlast  <= acc1 ? s1_axis_tlast : s0_axis_tlast;
      m_axis_tid    <= acc1;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tvalid && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Frame bookkeeping: remember the last winner and count completed frames.
  always_ff @(posedge aclk) begin
    if (areset) begin
      last_served <= 1'b1;
      frame_count <= 16'd0;
    end else if (frame_done) begin
      last_served <= acc1;
      frame_count <= frame_count + 16'd1;
    end
  end

  // Seed strobe: high for the first cycle of each grant.
  always_ff @(posedge aclk) begin
    if (areset) begin
      seed_tvalid <= 1'b0;
    end else begin
      seed_tvalid <= (state == IDLE) && (state_next != IDLE);
    end
  end

`ifdef SCRAMBLER_ARB_SEED_ROTATE_EN
  logic [6:0] seed;

  // Seed rotation: 1..127 increment, skipping 0, advanced once per completed frame.
  always_ff @(posedge aclk) begin
    if (areset) begin
      seed <= SEED_INIT;
    end else if (frame_done) begin
      seed <= (seed == 7'd127) ? 7'd1 : (seed + 7'd1);
    end
  end

  assign seed_tdata = seed;
`else
  assign seed_tdata = SEED_INIT;
`endif

endmodule

// File: doc/scrambler_arb.md
SCRAMBLER_ARB -- requirements
Module: scrambler_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the tdata width of all streams.
REQ-002 The block SHALL have parameter SEED_INIT, default 7'h7F, meaning the first per-frame scrambler seed after reset; value 0 is illegal.
REQ-003 The block SHALL have one clock and SHALL reset synchronously on an active-high reset, on the ports below.
REQ-004 aclk  in  1  clock; all logic on rising edge.
REQ-005 areset  in  1  synchronous active-high reset.
REQ-006 s0_axis_tdata/tuser/tvalid/tlast  in  WIDTH/4/1/1  requester 0 stream.
REQ-007 s0_axis_tready  out  1  requester 0 ready.
REQ-008 s1_axis_tdata/tuser/tvalid/tlast  in  WIDTH/4/1/1  requester 1 stream.
REQ-009 s1_axis_tready  out  1  requester 1 ready.
REQ-010 m_axis_tdata/tuser/tvalid/tlast  out  WIDTH/4/1/1  registered stream to the scrambler.
REQ-011 m_axis_tid  out  1  source index of the current output beat.
REQ-012 m_axis_tready  in  1  scrambler ready.
REQ-013 seed_tdata  out  7  scrambler seed for the frame being granted.
REQ-014 seed_tvalid  out  1  one-cycle seed load strobe.
REQ-015 frame_count  out  16  number of completed frames, wrapping.

Function
REQ-016 The FSM SHALL have states IDLE, GRANT0 and GRANT1, with arbitration at frame granularity.
REQ-017 IDLE: both readys 0; when only sN_axis_tvalid is high -> GRANTN next cycle; when both are high -> the requester other than last_served (round-robin); when neither is high -> stay in IDLE.
REQ-018 GRANTN: sN_axis_tready = !m_axis_tvalid || m_axis_tready; the other ready = 0.
REQ-019 Each accepted beat SHALL be copied to the m_axis registers on the next edge, with m_axis_tvalid=1 and m_axis_tid=N (latency 1 cycle).
REQ-020 Without a new beat, m_axis_tvalid SHALL clear on an m_axis handshake; output registers SHALL hold while m_axis_tvalid=1 and m_axis_tready=0.
REQ-021 On an accepted beat with tlast=1 in GRANTN -> IDLE, last_served=N, and frame_count increments (16'hFFFF wraps to 0).
REQ-022 This SHALL impose exactly one idle cycle (IDLE) between frames; a grant SHALL never switch mid-frame.
REQ-023 seed_tvalid SHALL pulse for exactly the first cycle of each GRANTN, presenting the current seed on seed_tdata.
REQ-024 The seed register SHALL advance on frame completion (REQ-021) as an increment from 1 to 127 that wraps 127->1, never reaching 0.
REQ-025 When a requester drops tvalid mid-frame, the grant SHALL be held with no timeout.
REQ-026 tuser and tlast SHALL pass unmodified.

Reset
REQ-027 On areset=1: state=IDLE; last_served=1 (s0 wins the first tie); m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tid=0; seed=SEED_INIT; seed_tvalid=0; frame_count=0; both readys=0.
REQ-028 A reset during a frame SHALL abandon the frame with no partial-frame count, and the next grant SHALL be arbitrated from IDLE.

Configuration
REQ-029 Per-frame seed rotation SHALL be controlled by macro SCRAMBLER_ARB_SEED_ROTATE_EN.
REQ-030 With SCRAMBLER_ARB_SEED_ROTATE_EN defined, seed behaviour SHALL follow REQ-023 and REQ-024.
REQ-031 Without it, seed_tdata SHALL be constant SEED_INIT, seed_tvalid SHALL still pulse per REQ-023, and no seed register logic SHALL remain.

Verification
REQ-032 Reset, then a 3-beat frame on s0 only (m_axis_tready=1) -> seed_tvalid pulse with seed 7'h7F, 3 output beats with tid=0 each one cycle after input, frame_count=1.
REQ-033 s0 and s1 both hold 2-beat frames continuously -> output frame order s0,s1,s0,s1, one IDLE bubble between frames, seeds 7F,01,02,03.
REQ-034 m_axis_tready low for 4 cycles mid-frame -> the m_axis beat holds stable, the granted ready stays low while m_axis_tvalid=1, and no beat is lost or duplicated.
REQ-035 127 single-beat frames from reset -> seeds 7F,01,...,7E in sequence, and the 128th frame's seed is 7F again, never 00.
REQ-036 areset asserted after beat 2 of a 5-beat s1 frame -> next cycle m_axis_tvalid=0, frame_count=0, and the s0 request then wins even with s1 also requesting.
REQ-037 Build without SCRAMBLER_ARB_SEED_ROTATE_EN, 3 frames -> seed_tdata stays 7'h7F and seed_tvalid pulses 3 times.
